// File: rtl/alu_seq16_pkg.sv
// rtl/alu_seq16_pkg.sv - shared encodings and helpers for the 16-bit ALU sequencer
package alu_seq16_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_MOVA = 3'b101;

  localparam logic [3:0] MODE_ADD   = 4'b0000;
  localparam logic [3:0] MODE_AND   = 4'b0100;
  localparam logic [3:0] MODE_OR    = 4'b0101;
  localparam logic [3:0] MODE_XOR   = 4'b0110;
  localparam logic [3:0] MODE_INC   = 4'b1000;
  localparam logic [3:0] MODE_PASS1 = 4'b0010;
  localparam logic [3:0] MODE_PASS2 = 4'b0011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The high pass of INC only forwards b[15:8]; the carry is added by FIX.
  function automatic logic [3:0] alu_mode_for(input logic [2:0] op, input logic hi_pass);
    case (op)
      OP_ADD:  return MODE_ADD;
      OP_AND:  return MODE_AND;
      OP_OR:   return MODE_OR;
      OP_XOR:  return MODE_XOR;
      OP_INC:  return hi_pass ? MODE_PASS2 : MODE_INC;
      default: return MODE_PASS1;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_INC);
  endfunction

  function automatic logic [3:0] result_flags(input logic [15:0] r, input logic c);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = (r == 16'h0000);
    f[FLAG_C] = c;
    f[FLAG_S] = r[15];
    f[FLAG_O] = r[15] ^ r[14];
    return f;
  endfunction

endpackage

// File: rtl/alu_seq16_if.sv
// rtl/alu_seq16_if.sv - bus between the sequencer (master) and the external 8-bit ALU (slave)
interface alu_seq16_if;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic       alu_en;
  logic [3:0] alu_mode;
  logic [3:0] alu_cflags;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;

  modport master (
    output alu_op1, alu_op2, alu_en, alu_mode, alu_cflags,
    input  alu_out, alu_flags
  );

  modport slave (
    input  alu_op1, alu_op2, alu_en, alu_mode, alu_cflags,
    output alu_out, alu_flags
  );
endinterface

// File: rtl/alu_seq16.sv
// rtl/alu_seq16.sv - 16-bit operation sequencer built from low/high/carry-fix 8-bit ALU passes
module alu_seq16
  import alu_seq16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags,
  alu_seq16_if.master alu
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic        c_lo_q, c_lo_d;
  logic        c_hi_q, c_hi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic        en_q, en_d;
  logic [3:0]  mode_q, mode_d;

  logic        finish;
  logic [7:0]  fin_hi;
  logic        fin_c;
  logic        c_hi_now;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    res_lo_d = res_lo_q;
    c_lo_d   = c_lo_q;
    c_hi_d   = c_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    en_d     = en_q;
    mode_d   = mode_q;
    finish   = 1'b0;
    fin_hi   = alu.alu_out;
    fin_c    = 1'b0;
    c_hi_now = (op_q == OP_ADD) && alu.alu_flags[FLAG_C];

    // ALU drives are loaded on entry to each state, so the ALU sees them during that state.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_hi_d  = a[15:8];
          b_hi_d  = b[15:8];
          op1_d   = a[7:0];
          op2_d   = b[7:0];
          en_d    = 1'b1;
          mode_d  = alu_mode_for(op, 1'b0);
          busy_d  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        res_lo_d = alu.alu_out;
        c_lo_d   = is_arith(op_q) && alu.alu_flags[FLAG_C];
        op1_d    = a_hi_q;
        op2_d    = b_hi_q;
        mode_d   = alu_mode_for(op_q, 1'b1);
        state_d  = ST_HI;
      end
      ST_HI: begin
        if (c_lo_q && is_arith(op_q)) begin
          c_hi_d  = c_hi_now;
          op1_d   = 8'h00;
          op2_d   = alu.alu_out;
          mode_d  = MODE_INC;
          state_d = ST_FIX;
        end else begin
          finish = 1'b1;
          fin_c  = c_hi_now;
        end
      end
      ST_FIX: begin
        finish = 1'b1;
        fin_c  = c_hi_q || alu.alu_flags[FLAG_C];
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        mode_d  = 4'b0000;
      end
    endcase

    // Carry out of logic/move passes is stale ALU state and never reaches the flags.
    if (finish) begin
      result_d = {fin_hi, res_lo_q};
      flags_d  = result_flags({fin_hi, res_lo_q}, is_arith(op_q) && fin_c);
      c_hi_d   = fin_c;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      en_d     = 1'b0;
      mode_d   = 4'b0000;
      op1_d    = 8'h00;
      op2_d    = 8'h00;
      state_d  = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'b000;
      a_hi_q   <= 8'h00;
      b_hi_q   <= 8'h00;
      res_lo_q <= 8'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 4'b0000;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      en_q     <= 1'b0;
      mode_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      res_lo_q <= res_lo_d;
      c_lo_q   <= c_lo_d;
      c_hi_q   <= c_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign flags          = flags_q;
  assign alu.alu_op1    = op1_q;
  assign alu.alu_op2    = op2_q;
  assign alu.alu_en     = en_q;
  assign alu.alu_mode   = mode_q;
  assign alu.alu_cflags = 4'b0000;

endmodule
